// File: rtl/issue_hazard_ctrl_pkg.sv
// Shared definitions for the issue hazard / forwarding / flush controller.
// Contents: execution-unit encoding, forward-select constants and the default
// lane count and register-index width.
package issue_hazard_ctrl_pkg;

    localparam int ISSUE_W_DEF = 2;
    localparam int REG_AW_DEF  = 5;

    typedef enum logic [1:0] {
        UNIT_ALU = 2'd0,
        UNIT_MUL = 2'd1,
        UNIT_LSU = 2'd2
    } unit_e;

    // Forward select encoding: 0 = regfile, FWD_EX_BASE+k = EX lane k,
    // FWD_WB_BASE+k = WB lane k.
    localparam int FWD_RF      = 0;
    localparam int FWD_EX_BASE = 1;
    localparam int FWD_WB_BASE = FWD_EX_BASE + ISSUE_W_DEF;

    // WB base for a lane count other than the default.
    function automatic int fwd_wb_base(input int issue_w);
        return FWD_EX_BASE + issue_w;
    endfunction

endpackage

// File: rtl/issue_hazard_ctrl_fwd_sel_prio.sv
// Single-operand forwarding priority matcher.
// Ports:
//   rs                     source register index
//   ex_valid/ex_wen/ex_rd  EX-stage writers, ex_fwd_ok = EX result ready
//   wb_valid/wb_wen/wb_rd  WB-stage writers
//   sel                    forward select (regfile / EX lane / WB lane)
//   ex_pending             winning source is an EX lane whose result is not ready
module fwd_sel_prio
    import issue_hazard_ctrl_pkg::*;
#(
    parameter int ISSUE_W  = ISSUE_W_DEF,
    parameter int REG_AW   = REG_AW_DEF,
    parameter int FW_SEL_W = $clog2(2*ISSUE_W+1)
) (
    input  logic [REG_AW-1:0]         rs,
    input  logic [ISSUE_W-1:0]        ex_valid,
    input  logic [ISSUE_W-1:0]        ex_wen,
    input  logic [ISSUE_W-1:0]        ex_fwd_ok,
    input  logic [ISSUE_W*REG_AW-1:0] ex_rd,
    input  logic [ISSUE_W-1:0]        wb_valid,
    input  logic [ISSUE_W-1:0]        wb_wen,
    input  logic [ISSUE_W*REG_AW-1:0] wb_rd,
    output logic [FW_SEL_W-1:0]       sel,
    output logic                      ex_pending
);

    // Ascending scans with later overwrite: the youngest lane wins, and the
    // EX scan runs after the WB scan so any EX hit beats any WB hit.
    always_comb begin
        sel        = FW_SEL_W'(FWD_RF);
        ex_pending = 1'b0;
        if (rs != '0) begin
            for (int i = 0; i < ISSUE_W; i++) begin
                if (wb_valid[i] && wb_wen[i] && (wb_rd[i*REG_AW +: REG_AW] == rs))
                    sel = FW_SEL_W'(fwd_wb_base(ISSUE_W) + i);
            end
            for (int i = 0; i < ISSUE_W; i++) begin
                if (ex_valid[i] && ex_wen[i] && (ex_rd[i*REG_AW +: REG_AW] == rs)) begin
                    sel        = FW_SEL_W'(FWD_EX_BASE + i);
                    ex_pending = !ex_fwd_ok[i];
                end
            end
        end
    end

endmodule

// File: rtl/issue_hazard_ctrl.sv
// N-issue hazard, forwarding and flush controller between decode and EX/WB.
// Ports:
//   dec_*                    decode bundle (lane 0 oldest)
//   ex_*, wb_*               in-flight writers for forwarding / hazard checks
//   lsu_done                 outstanding load/store completes (pulse)
//   fifo_full, buffer_full   fetch FIFO / issue buffer back-pressure
//   redir_req, redir_addr    taken branch/jump resolved in EX, per lane
//   issue_mask               lanes leaving decode this cycle
//   fwd_sel1/2               per-lane operand forward selects
//   *_stall                  stage holds
//   redirect_*, flush_*      registered redirect and flush pulses
//   flush_ex_mask            same-cycle kill of EX lanes younger than the winner
module issue_hazard_ctrl
    import issue_hazard_ctrl_pkg::*;
#(
    parameter int ISSUE_W  = ISSUE_W_DEF,
    parameter int REG_AW   = REG_AW_DEF,
    parameter int XLEN     = 32,
    parameter int MUL_LAT  = 3,
    parameter int FW_SEL_W = $clog2(2*ISSUE_W+1)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [ISSUE_W-1:0]          dec_valid,
    input  logic [ISSUE_W*REG_AW-1:0]   dec_rs1,
    input  logic [ISSUE_W*REG_AW-1:0]   dec_rs2,
    input  logic [ISSUE_W*REG_AW-1:0]   dec_rd,
    input  logic [ISSUE_W-1:0]          dec_wen,
    input  logic [ISSUE_W*2-1:0]        dec_unit,
    input  logic [ISSUE_W-1:0]          ex_valid,
    input  logic [ISSUE_W-1:0]          ex_wen,
    input  logic [ISSUE_W*REG_AW-1:0]   ex_rd,
    input  logic [ISSUE_W-1:0]          ex_fwd_ok,
    input  logic [ISSUE_W-1:0]          wb_valid,
    input  logic [ISSUE_W-1:0]          wb_wen,
    input  logic [ISSUE_W*REG_AW-1:0]   wb_rd,
    input  logic                        lsu_done,
    input  logic                        fifo_full,
    input  logic                        buffer_full,
    input  logic [ISSUE_W-1:0]          redir_req,
    input  logic [ISSUE_W*XLEN-1:0]     redir_addr,
    output logic [ISSUE_W-1:0]          issue_mask,
    output logic [ISSUE_W*FW_SEL_W-1:0] fwd_sel1,
    output logic [ISSUE_W*FW_SEL_W-1:0] fwd_sel2,
    output logic                        fetch_stall,
    output logic                        dec_stall,
    output logic                        ex_stall,
    output logic                        redirect_valid,
    output logic [XLEN-1:0]             redirect_pc,
    output logic                        flush_fetch,
    output logic                        flush_decode,
    output logic [ISSUE_W-1:0]          flush_ex_mask
);

    localparam int NUM_REGS = 2**REG_AW;
    localparam int CNT_W    = $clog2(MUL_LAT+1);

    logic [NUM_REGS-1:0] mul_busy;
    logic [CNT_W-1:0]    mul_cnt [NUM_REGS];
    logic                lsu_out;
    logic                lsu_wen_q;
    logic [REG_AW-1:0]   lsu_rd;

    logic [NUM_REGS-1:0] reg_busy;
    logic [ISSUE_W-1:0]  pend1, pend2, hazard;
    logic                lsu_seen, chain;
    logic                redir_take;
    logic [XLEN-1:0]     redir_win_addr;

    for (genvar g = 0; g < ISSUE_W; g++) begin : g_lane
        fwd_sel_prio #(.ISSUE_W(ISSUE_W), .REG_AW(REG_AW), .FW_SEL_W(FW_SEL_W)) u_rs1 (
            .rs(dec_rs1[g*REG_AW +: REG_AW]),
            .ex_valid(ex_valid), .ex_wen(ex_wen), .ex_fwd_ok(ex_fwd_ok), .ex_rd(ex_rd),
            .wb_valid(wb_valid), .wb_wen(wb_wen), .wb_rd(wb_rd),
            .sel(fwd_sel1[g*FW_SEL_W +: FW_SEL_W]), .ex_pending(pend1[g])
        );
        fwd_sel_prio #(.ISSUE_W(ISSUE_W), .REG_AW(REG_AW), .FW_SEL_W(FW_SEL_W)) u_rs2 (
            .rs(dec_rs2[g*REG_AW +: REG_AW]),
            .ex_valid(ex_valid), .ex_wen(ex_wen), .ex_fwd_ok(ex_fwd_ok), .ex_rd(ex_rd),
            .wb_valid(wb_valid), .wb_wen(wb_wen), .wb_rd(wb_rd),
            .sel(fwd_sel2[g*FW_SEL_W +: FW_SEL_W]), .ex_pending(pend2[g])
        );
    end

    assign ex_stall    = lsu_out && !lsu_done;
    assign dec_stall   = (issue_mask != dec_valid) || buffer_full;
    assign fetch_stall = fifo_full || dec_stall;

    // x0 is never marked, so indexing with rs == 0 always reads not-busy.
    always_comb begin
        reg_busy = mul_busy;
        if (lsu_out && lsu_wen_q)
            reg_busy[lsu_rd] = 1'b1;
    end

    // Oldest requesting lane wins; requests are ignored while EX is stalled
    // because the requesting lane is held and will present again.
    always_comb begin
        redir_take     = 1'b0;
        redir_win_addr = '0;
        flush_ex_mask  = '0;
        if (!ex_stall) begin
            for (int j = 0; j < ISSUE_W; j++) begin
                if (redir_take) begin
                    flush_ex_mask[j] = 1'b1;
                end else if (redir_req[j]) begin
                    redir_take     = 1'b1;
                    redir_win_addr = redir_addr[j*XLEN +: XLEN];
                end
            end
        end
    end

    always_comb begin
        hazard     = '0;
        issue_mask = '0;
        lsu_seen   = lsu_out;
        chain      = 1'b1;
        for (int j = 0; j < ISSUE_W; j++) begin
            hazard[j] = reg_busy[dec_rs1[j*REG_AW +: REG_AW]] || reg_busy[dec_rs2[j*REG_AW +: REG_AW]]
                        || pend1[j] || pend2[j];
            for (int i = 0; i < ISSUE_W; i++) begin
                if ((i < j) && dec_valid[i] && dec_wen[i] && (dec_rd[i*REG_AW +: REG_AW] != '0) &&
                    ((dec_rd[i*REG_AW +: REG_AW] == dec_rs1[j*REG_AW +: REG_AW]) ||
                     (dec_rd[i*REG_AW +: REG_AW] == dec_rs2[j*REG_AW +: REG_AW])))
                    hazard[j] = 1'b1;
            end
            if ((dec_unit[j*2 +: 2] == UNIT_LSU) && lsu_seen)
                hazard[j] = 1'b1;
            if (dec_valid[j] && (dec_unit[j*2 +: 2] == UNIT_LSU))
                lsu_seen = 1'b1;
            chain         = chain && dec_valid[j] && !hazard[j];
            issue_mask[j] = chain;
        end
        if (buffer_full || redir_take)
            issue_mask = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mul_busy <= '0;
            for (int r = 0; r < NUM_REGS; r++)
                mul_cnt[r] <= '0;
            lsu_out        <= 1'b0;
            lsu_wen_q      <= 1'b0;
            lsu_rd         <= '0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            flush_fetch    <= 1'b0;
            flush_decode   <= 1'b0;
        end else begin
            if (!ex_stall) begin
                for (int r = 0; r < NUM_REGS; r++) begin
                    if (mul_busy[r]) begin
                        mul_cnt[r] <= mul_cnt[r] - 1'b1;
                        if (mul_cnt[r] == CNT_W'(1))
                            mul_busy[r] <= 1'b0;
                    end
                end
            end
            if (lsu_out && lsu_done)
                lsu_out <= 1'b0;
            // Issue updates come after the drains so a same-cycle set wins.
            for (int j = 0; j < ISSUE_W; j++) begin
                if (issue_mask[j]) begin
                    if ((dec_unit[j*2 +: 2] == UNIT_MUL) && (dec_rd[j*REG_AW +: REG_AW] != '0)) begin
                        mul_busy[dec_rd[j*REG_AW +: REG_AW]] <= 1'b1;
                        mul_cnt[dec_rd[j*REG_AW +: REG_AW]]  <= CNT_W'(MUL_LAT-1);
                    end
                    if (dec_unit[j*2 +: 2] == UNIT_LSU) begin
                        lsu_out   <= 1'b1;
                        lsu_wen_q <= dec_wen[j] && (dec_rd[j*REG_AW +: REG_AW] != '0);
                        lsu_rd    <= dec_rd[j*REG_AW +: REG_AW];
                    end
                end
            end
            redirect_valid <= redir_take;
            flush_fetch    <= redir_take;
            flush_decode   <= redir_take;
            if (redir_take)
                redirect_pc <= redir_win_addr;
        end
    end

endmodule
